// File: rtl/chi_slave_node.sv
// CHI slave node: single-outstanding ReadNoSnp/WriteNoSnp target
// backed by a small word-addressed storage array.
package chi_pkg;

    localparam logic [1:0] FLIT_REQ = 2'd0;
    localparam logic [1:0] FLIT_RSP = 2'd1;
    localparam logic [1:0] FLIT_DAT = 2'd2;

    localparam logic [6:0] OP_READ_NO_SNP  = 7'h04;
    localparam logic [6:0] OP_WRITE_UNIQUE = 7'h18;
    localparam logic [6:0] OP_WRITE_NO_SNP = 7'h1D;
    localparam logic [6:0] OP_COMP         = 7'h04;
    localparam logic [6:0] OP_COMP_DATA    = 7'h04;

    typedef struct packed {
        logic [1:0]  flit_type;
        logic [6:0]  opcode;
        logic [31:0] address;
        logic [7:0]  txn_id;
        logic [31:0] data;
        logic [3:0]  src_id;
        logic [3:0]  tgt_id;
    } chi_flit;

endpackage

module chi_slave_node
    import chi_pkg::*;
#(
    parameter logic [3:0] NODE_ID     = 4'd2,
    parameter int         MEM_DEPTH   = 16,
    parameter int         MEM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flit_valid,
    input  chi_flit    flit_in,
    output logic       flit_ready,
    output logic       flit_valid_out,
    output chi_flit    flit_out,
    input  logic       flit_ready_out,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_DO,
        RESP
    } state_t;

    state_t        state;
    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic [7:0]    txn_q;
    logic [3:0]    src_q;
    logic [3:0]    cnt_q;
    logic [IW-1:0] idx_q;
    logic          for_me;
    logic          is_rd;
    logic          is_wr;

    // Classify the presented flit against our node ID and opcode set
    always_comb begin
        for_me = (flit_in.flit_type == FLIT_REQ)
              && (flit_in.tgt_id == NODE_ID);
        is_rd  = for_me && (flit_in.opcode == OP_READ_NO_SNP);
        is_wr  = for_me && (flit_in.opcode == OP_WRITE_NO_SNP);
    end

    assign idx_q      = addr_q[IW+1:2];
    assign flit_ready = rst && (state == IDLE);
    assign busy       = (state != IDLE);

    // Transaction FSM, storage and registered response flit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            flit_valid_out <= 1'b0;
            flit_out       <= '0;
            drop_count     <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            txn_q          <= '0;
            src_q          <= '0;
            cnt_q          <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (flit_valid) begin
                        addr_q <= flit_in.address;
                        data_q <= flit_in.data;
                        txn_q  <= flit_in.txn_id;
                        src_q  <= flit_in.src_id;
                        cnt_q  <= 4'(MEM_LATENCY - 1);
                        if (is_rd) begin
                            state <= RD_WAIT;
                        end else if (is_wr) begin
                            state <= WR_DO;
                        end else if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state              <= RESP;
                        flit_valid_out     <= 1'b1;
                        flit_out.flit_type <= FLIT_DAT;
                        flit_out.opcode    <= OP_COMP_DATA;
                        flit_out.address   <= addr_q;
                        flit_out.txn_id    <= txn_q;
                        flit_out.data      <= mem[idx_q];
                        flit_out.src_id    <= NODE_ID;
                        flit_out.tgt_id    <= src_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_DO: begin
                    mem[idx_q]         <= data_q;
                    state              <= RESP;
                    flit_valid_out     <= 1'b1;
                    flit_out.flit_type <= FLIT_RSP;
                    flit_out.opcode    <= OP_COMP;
                    flit_out.address   <= addr_q;
                    flit_out.txn_id    <= txn_q;
                    flit_out.data      <= '0;
                    flit_out.src_id    <= NODE_ID;
                    flit_out.tgt_id    <= src_q;
                end
                RESP: begin
                    if (flit_ready_out) begin
                        state          <= IDLE;
                        flit_valid_out <= 1'b0;
                        flit_out       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/chi_slave_node.md
CHI_SLAVE_NODE -- requirements
Module: chi_slave_node

Interface
REQ-001 SHALL have parameter NODE_ID, default 4'd2: own CHI node ID, compared against tgt_id and driven as src_id.
REQ-002 SHALL have parameter MEM_DEPTH, default 16: number of 32-bit storage words (power of two, 2..256).
REQ-003 SHALL have parameter MEM_LATENCY, default 2: extra wait cycles before a read response (1..15).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port flit_valid  input  1: home node presents a request flit.
REQ-007 SHALL have port flit_in  input  chi_flit: request flit (flit_type, opcode, address, txn_id, data, src_id, tgt_id).
REQ-008 SHALL have port flit_ready  output  1: slave accepts flit_in this cycle.
REQ-009 SHALL have port flit_valid_out  output  1: response flit valid.
REQ-010 SHALL have port flit_out  output  chi_flit: response flit.
REQ-011 SHALL have port flit_ready_out  input  1: home node accepts flit_out.
REQ-012 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-013 SHALL have port drop_count  output  8: saturating count of discarded flits.

Function
REQ-014 SHALL implement FSM states IDLE, RD_WAIT, WR_DO, RESP.
REQ-015 SHALL drive flit_ready=1 only in IDLE; a flit is accepted on an edge where flit_valid && flit_ready.
REQ-016 SHALL index storage with address[log2(MEM_DEPTH)+1:2]; upper address bits ignored, no alignment check.
REQ-017 SHALL, on accepting FLIT_REQ ReadNoSnp with tgt_id==NODE_ID, latch txn_id, src_id and index, and enter RD_WAIT for MEM_LATENCY cycles, then enter RESP.
REQ-018 SHALL, in RESP after a read, drive flit_out: flit_type=FLIT_DAT, opcode=CompData, data=storage[index] sampled on entry to RESP, txn_id=latched txn_id, src_id=NODE_ID, tgt_id=latched src_id, address=latched address.
REQ-019 SHALL, on accepting FLIT_REQ WriteNoSnp with tgt_id==NODE_ID, enter WR_DO; WR_DO writes flit data to storage[index] on the next edge and enters RESP.
REQ-020 SHALL, in RESP after a write, drive flit_type=FLIT_RSP, opcode=Comp, data=0, with txn_id/src_id/tgt_id/address as in REQ-018.
REQ-021 SHALL keep flit_valid_out=1 and flit_out stable in RESP until flit_ready_out=1; the handshake edge returns to IDLE.
REQ-022 SHALL set read latency to MEM_LATENCY+1 cycles (accept edge to first valid cycle) and write latency to 2 cycles.
REQ-023 SHALL, on accepting any flit with tgt_id!=NODE_ID, flit_type!=FLIT_REQ or opcode not ReadNoSnp/WriteNoSnp, discard it, stay in IDLE, send no response and increment drop_count, saturating at 255.
REQ-024 SHALL drive flit_out='0 whenever flit_valid_out=0.
REQ-025 SHALL process one transaction at a time; back-to-back requests are accepted earliest in the cycle after the response handshake.
REQ-026 SHALL, for a write then read of the same index, return the written data.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, flit_ready=0, flit_valid_out=0, flit_out='0, busy=0, drop_count=0 and all storage words to 0.
REQ-028 SHALL, when reset is asserted mid-transaction, abandon it with no response; a write not yet performed in WR_DO is lost.
REQ-029 SHALL drive flit_ready=1 in the first cycle after rst deasserts.

Verification
REQ-030 SHALL pass: after reset, ReadNoSnp addr 0x10, txn 0x02, src 0 -> CompData, data 0x00000000, txn 0x02, tgt 0, src 2, valid 3 cycles after accept.
REQ-031 SHALL pass: WriteNoSnp addr 0x10, data 0xABCD1234, txn 0x01, then ReadNoSnp addr 0x10, txn 0x05 -> Comp txn 0x01 after 2 cycles; CompData 0xABCD1234 txn 0x05.
REQ-032 SHALL pass: WriteNoSnp addr 0x50 (aliases index 4), data 0x9205B98F, then ReadNoSnp addr 0x10 -> CompData 0x9205B98F.
REQ-033 SHALL pass: flit_ready_out held 0 for 5 cycles during RESP -> flit_valid_out and flit_out stable, flit_ready=0 throughout; one handshake only.
REQ-034 SHALL pass: 3 flits with tgt_id=1 plus 1 WriteUnique with tgt_id=2 -> no responses, drop_count=4; 300 such flits -> drop_count=255.
REQ-035 SHALL pass: rst pulsed low during RD_WAIT -> flit_valid_out never rises for that txn, busy=0, next request handled normally.
